vga_timing_gen: RTL and testbench

Generates 800x600@56Hz VESA raster timing from the 36 MHz pixel clock. Drives h_coord/v_coord to the game/render logic and takes back its 4-bit RGB for the same coordinate. Registers RGB together with hsync, vsync and display enable, and blanks RGB outside the active area. Provides frame and line strobes plus a frame counter for frame-rate logic.

---
 rtl/vga_pkg.sv | 34 +++
 rtl/vga_axis_counter.sv | 25 ++
 rtl/vga_timing_gen.sv | 122 ++++++++++++
 tb/tb_vga_timing_gen.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Timing constants and shared types for the 800x600@56Hz raster generator.
package vga_pkg;

    localparam int H_ACTIVE = 800;
    localparam int H_FP     = 24;
    localparam int H_SYNC   = 72;
    localparam int H_BP     = 128;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 600;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 22;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic H_SYNC_POL = 1'b1;
    localparam logic V_SYNC_POL = 1'b1;

    localparam int H_W  = 11;
    localparam int V_W  = 10;
    localparam int FC_W = 16;

    localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-TOTAL position counter for one raster axis; wrap flags the step from TOTAL-1 back to 0.
module vga_axis_counter #(
    parameter int TOTAL = 1024,
    parameter int W     = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         advance,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    assign wrap = advance && (count == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (advance) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running h/v counters, one registered output stage that keeps
// sync, display enable, blanked RGB and line/frame strobes aligned at latency 1.
module vga_timing_gen
    import vga_pkg::H_W, vga_pkg::V_W, vga_pkg::FC_W, vga_pkg::rgb12_t;
#(
    parameter int   H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int   H_FP       = vga_pkg::H_FP,
    parameter int   H_SYNC     = vga_pkg::H_SYNC,
    parameter int   H_BP       = vga_pkg::H_BP,
    parameter int   V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int   V_FP       = vga_pkg::V_FP,
    parameter int   V_SYNC     = vga_pkg::V_SYNC,
    parameter int   V_BP       = vga_pkg::V_BP,
    parameter logic H_SYNC_POL = vga_pkg::H_SYNC_POL,
    parameter logic V_SYNC_POL = vga_pkg::V_SYNC_POL
) (
    input  logic            pixel_clk,
    input  logic            rst_n,
    input  logic [3:0]      red_in,
    input  logic [3:0]      green_in,
    input  logic [3:0]      blue_in,
    output logic [H_W-1:0]  h_coord,
    output logic [V_W-1:0]  v_coord,
    output logic [FC_W-1:0] frame_count,
    output logic            hsync,
    output logic            vsync,
    output logic            display_on,
    output logic [3:0]      red,
    output logic [3:0]      green,
    output logic [3:0]      blue,
    output logic            frame_start,
    output logic            line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [H_W-1:0] H_ACT_END = H_W'(H_ACTIVE);
    localparam logic [V_W-1:0] V_ACT_END = V_W'(V_ACTIVE);
    localparam logic [H_W-1:0] HS_START  = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] HS_END    = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [V_W-1:0] VS_START  = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] VS_END    = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [H_W-1:0] h_cnt_p0;
    logic [V_W-1:0] v_cnt_p0;
    logic           h_wrap;
    logic           v_wrap;

    vga_axis_counter #(.TOTAL(H_TOTAL), .W(H_W)) u_h_counter (
        .clk     (pixel_clk),
        .rst_n   (rst_n),
        .advance (1'b1),
        .count   (h_cnt_p0),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL), .W(V_W)) u_v_counter (
        .clk     (pixel_clk),
        .rst_n   (rst_n),
        .advance (h_wrap),
        .count   (v_cnt_p0),
        .wrap    (v_wrap)
    );

    assign h_coord = h_cnt_p0;
    assign v_coord = v_cnt_p0;

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            frame_count <= '0;
        end else if (v_wrap) begin
            frame_count <= frame_count + FC_W'(1);
        end
    end

    // Stage 0: decode directly from the counter registers
    logic   active_p0;
    logic   hs_p0;
    logic   vs_p0;
    logic   line_p0;
    logic   frame_p0;
    rgb12_t rgb_p0;

    always_comb begin
        active_p0 = (h_cnt_p0 < H_ACT_END) && (v_cnt_p0 < V_ACT_END);
        hs_p0     = (h_cnt_p0 >= HS_START) && (h_cnt_p0 <= HS_END);
        vs_p0     = (v_cnt_p0 >= VS_START) && (v_cnt_p0 <= VS_END);
        line_p0   = (h_cnt_p0 == '0);
        frame_p0  = (h_cnt_p0 == '0) && (v_cnt_p0 == '0);
        rgb_p0    = '0;
        if (active_p0) begin
            rgb_p0 = '{r: red_in, g: green_in, b: blue_in};
        end
    end

    // Stage 1: every output registered once so they stay mutually aligned
    rgb12_t rgb_p1;

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            display_on  <= 1'b0;
            rgb_p1      <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= hs_p0 ? H_SYNC_POL : ~H_SYNC_POL;
            vsync       <= vs_p0 ? V_SYNC_POL : ~V_SYNC_POL;
            display_on  <= active_p0;
            rgb_p1      <= rgb_p0;
            line_start  <= line_p0;
            frame_start <= frame_p0;
        end
    end

    assign red   = rgb_p1.r;
    assign green = rgb_p1.g;
    assign blue  = rgb_p1.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line timing and a shrunk instance for frame timing.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] h;
        logic [9:0]  v;
        logic [15:0] fc;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic        ls;
        logic [11:0] rgb;
    } obs_t;

    logic pixel_clk = 1'b0;
    always #14 pixel_clk = ~pixel_clk;

    logic        rst_n_f, rst_n_s;
    logic [3:0]  r_f, g_f, b_f, r_s, g_s, b_s;
    logic [10:0] h_f, h_s;
    logic [9:0]  v_f, v_s;
    logic [15:0] fc_f, fc_s;
    logic        hsync_f, vsync_f, de_f, fs_f, ls_f;
    logic        hsync_s, vsync_s, de_s, fs_s, ls_s;
    logic [3:0]  red_f, green_f, blue_f, red_s, green_s, blue_s;

    vga_timing_gen u_full (
        .pixel_clk   (pixel_clk),
        .rst_n       (rst_n_f),
        .red_in      (r_f),
        .green_in    (g_f),
        .blue_in     (b_f),
        .h_coord     (h_f),
        .v_coord     (v_f),
        .frame_count (fc_f),
        .hsync       (hsync_f),
        .vsync       (vsync_f),
        .display_on  (de_f),
        .red         (red_f),
        .green       (green_f),
        .blue        (blue_f),
        .frame_start (fs_f),
        .line_start  (ls_f)
    );

    vga_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(3),
        .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0)
    ) u_small (
        .pixel_clk   (pixel_clk),
        .rst_n       (rst_n_s),
        .red_in      (r_s),
        .green_in    (g_s),
        .blue_in     (b_s),
        .h_coord     (h_s),
        .v_coord     (v_s),
        .frame_count (fc_s),
        .hsync       (hsync_s),
        .vsync       (vsync_s),
        .display_on  (de_s),
        .red         (red_s),
        .green       (green_s),
        .blue        (blue_s),
        .frame_start (fs_s),
        .line_start  (ls_s)
    );

    obs_t obs_f, obs_s;
    assign obs_f = {h_f, v_f, fc_f, hsync_f, vsync_f, de_f, fs_f, ls_f, red_f, green_f, blue_f};
    assign obs_s = {h_s, v_s, fc_s, hsync_s, vsync_s, de_s, fs_s, ls_s, red_s, green_s, blue_s};

    // Reference timing for index 0 (full) and 1 (small)
    int   HA [2] = '{800, 16};
    int   HFP[2] = '{24, 4};
    int   HSY[2] = '{72, 6};
    int   HT [2] = '{1024, 32};
    int   VA [2] = '{600, 12};
    int   VFP[2] = '{1, 1};
    int   VSY[2] = '{2, 2};
    int   VT [2] = '{625, 18};
    logic HPOL[2] = '{1'b1, 1'b0};
    logic VPOL[2] = '{1'b1, 1'b0};

    int   mh[2], mv[2], mfc[2];
    obs_t q_f[$], q_s[$];
    int   n_checks = 0, n_pass = 0, n_fail = 0, cyc = 0;

    function automatic obs_t predict(int i, logic rn, logic [11:0] rgb_in);
        obs_t e;
        logic act;
        e = '0;
        if (!rn) begin
            e.hs = ~HPOL[i];
            e.vs = ~VPOL[i];
            mh[i] = 0; mv[i] = 0; mfc[i] = 0;
        end else begin
            act   = (mh[i] < HA[i]) && (mv[i] < VA[i]);
            e.hs  = (mh[i] >= HA[i] + HFP[i] && mh[i] < HA[i] + HFP[i] + HSY[i]) ? HPOL[i] : ~HPOL[i];
            e.vs  = (mv[i] >= VA[i] + VFP[i] && mv[i] < VA[i] + VFP[i] + VSY[i]) ? VPOL[i] : ~VPOL[i];
            e.de  = act;
            e.rgb = act ? rgb_in : 12'h000;
            e.ls  = (mh[i] == 0);
            e.fs  = (mh[i] == 0) && (mv[i] == 0);
            mh[i] = mh[i] + 1;
            if (mh[i] == HT[i]) begin
                mh[i] = 0;
                mv[i] = mv[i] + 1;
                if (mv[i] == VT[i]) begin
                    mv[i]  = 0;
                    mfc[i] = (mfc[i] + 1) % 65536;
                end
            end
            e.h  = 11'(mh[i]);
            e.v  = 10'(mv[i]);
            e.fc = 16'(mfc[i]);
        end
        return e;
    endfunction

    task automatic chk_obs(string tag, obs_t act, obs_t exp);
        n_checks++;
        assert (act === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, act, exp);
        end
    endtask

    task automatic chk_int(string tag, int act, int exp);
        n_checks++;
        assert (act === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, act, exp);
        end
    endtask

    task automatic tick();
        q_f.push_back(predict(0, rst_n_f, {r_f, g_f, b_f}));
        q_s.push_back(predict(1, rst_n_s, {r_s, g_s, b_s}));
        @(posedge pixel_clk);
        #1;
        cyc++;
        chk_obs("full_outputs", obs_f, q_f.pop_front());
        chk_obs("small_outputs", obs_s, q_s.pop_front());
    endtask

    initial begin
        int n_fs_s, n_ls_s, n_de_s, last_fs_s, last_ls_s, vs_run, vs_max;
        int n_ls_f, n_hs_f, n_de_f, last_ls_f, hs_rise, de_fall, guard;
        logic [3:0] prev_h;

        rst_n_f = 1'b0; rst_n_s = 1'b0;
        r_f = 4'hF; g_f = 4'h0; b_f = 4'hA;
        r_s = 4'hF; g_s = 4'h0; b_s = 4'hA;
        repeat (4) tick();
        chk_int("reset_hsync_full", hsync_f, 0);
        chk_int("reset_vsync_small", vsync_s, 1);

        rst_n_f = 1'b1; rst_n_s = 1'b1;
        n_fs_s = 0; n_ls_s = 0; n_de_s = 0; last_fs_s = 0; last_ls_s = 0; vs_run = 0; vs_max = 0;
        n_ls_f = 0; n_hs_f = 0; n_de_f = 0; last_ls_f = 0; hs_rise = 0; de_fall = 0;
        for (int k = 1; k <= 1728; k++) begin
            tick();
            if (k == 1) begin
                chk_int("first_h", h_f, 1);
                chk_int("first_v", v_f, 0);
                chk_int("first_frame_start", fs_f, 1);
                chk_int("first_line_start", ls_f, 1);
                chk_int("first_display_on", de_f, 1);
                chk_int("first_rgb", {red_f, green_f, blue_f}, 12'hF0A);
            end
            if (k == 2) begin
                chk_int("second_frame_start", fs_f, 0);
                chk_int("second_line_start", ls_f, 0);
            end
            if (fs_s) begin
                n_fs_s++;
                if (last_fs_s > 0) chk_int("small_frame_period", k - last_fs_s, 576);
                last_fs_s = k;
            end
            if (ls_s) begin
                n_ls_s++;
                if (last_ls_s > 0) chk_int("small_line_period", k - last_ls_s, 32);
                last_ls_s = k;
            end
            n_de_s += int'(de_s);
            if (vsync_s == 1'b0) vs_run++;
            else begin
                if (vs_run > vs_max) vs_max = vs_run;
                vs_run = 0;
            end
            if (ls_f) begin
                n_ls_f++;
                if (last_ls_f > 0) chk_int("full_line_period", k - last_ls_f, 1024);
                last_ls_f = k;
            end
            if (n_ls_f == 1) begin
                n_hs_f += int'(hsync_f);
                n_de_f += int'(de_f);
                if (hsync_f && hs_rise == 0) hs_rise = k;
                if (!de_f && de_fall == 0) de_fall = k;
            end
        end
        chk_int("small_frame_count", fc_s, 3);
        chk_int("small_frame_starts", n_fs_s, 3);
        chk_int("small_line_starts", n_ls_s, 54);
        chk_int("small_display_cycles", n_de_s, 576);
        chk_int("small_vsync_run", vs_max, 64);
        chk_int("full_line_starts", n_ls_f, 2);
        chk_int("full_hsync_cycles", n_hs_f, 72);
        chk_int("full_display_cycles", n_de_f, 800);
        chk_int("full_hsync_rise_sample", hs_rise, 825);
        chk_int("full_de_fall_sample", de_fall, 801);

        // Render logic feeds back red = h_coord[3:0]
        guard = 0;
        while (!(mh[0] == 500 && mv[0] == 2) && guard < 4000) begin
            prev_h = h_f[3:0];
            r_f = h_f[3:0];
            g_f = 4'($urandom);
            b_f = 4'($urandom);
            tick();
            if (de_f) chk_int("red_follows_h", red_f, prev_h);
            guard++;
        end
        chk_int("reach_full_500_2", int'(guard < 4000), 1);

        rst_n_f = 1'b0;
        repeat (3) tick();
        chk_int("midreset_h", h_f, 0);
        chk_int("midreset_v", v_f, 0);
        chk_int("midreset_de", de_f, 0);
        rst_n_f = 1'b1;
        r_f = 4'hF; g_f = 4'h0; b_f = 4'hA;
        tick();
        chk_int("after_reset_fs", fs_f, 1);
        chk_int("after_reset_h", h_f, 1);

        guard = 0;
        while (!(mh[1] == 10 && mv[1] == 6) && guard < 1000) begin
            tick();
            guard++;
        end
        chk_int("reach_small_10_6", int'(guard < 1000), 1);
        rst_n_s = 1'b0;
        repeat (3) tick();
        chk_int("small_reset_fc", fc_s, 0);
        rst_n_s = 1'b1;
        tick();
        chk_int("small_after_reset_fs", fs_s, 1);
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!fs_s && guard < 1000);
        chk_int("small_fs_period_after_reset", guard, 576);
        chk_int("small_fc_after_reset_frame", fc_s, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
